// File: rtl/leiwand_rv32_wb_intercon_pkg.sv
// Shared encodings for the leiwand_rv32 Wishbone interconnect:
// FSM state codes and the data value returned on an error ack.
`ifndef LEIWAND_RV32_CONSTANTS
`define LEIWAND_RV32_CONSTANTS
`define LEIWAND_WB_ST_IDLE    2'd0
`define LEIWAND_WB_ST_WAIT_S0 2'd1
`define LEIWAND_WB_ST_WAIT_S1 2'd2
`define LEIWAND_WB_ST_ERR_ACK 2'd3
`define LEIWAND_WB_ERR_DATA   '0
`endif

package leiwand_rv32_wb_intercon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = `LEIWAND_WB_ST_IDLE,
    ST_WAIT_S0 = `LEIWAND_WB_ST_WAIT_S0,
    ST_WAIT_S1 = `LEIWAND_WB_ST_WAIT_S1,
    ST_ERR_ACK = `LEIWAND_WB_ST_ERR_ACK
  } wb_state_e;

endpackage

// File: rtl/leiwand_rv32_wb_intercon_addr_decode.sv
// Combinational two-window address decoder (module
// leiwand_rv32_wb_addr_decode), reusable by other SoC tops.
module leiwand_rv32_wb_addr_decode #(
  parameter int unsigned     AW      = 32,
  parameter logic [AW-1:0]   S0_BASE = 32'h1000_0000,
  parameter int unsigned     S0_SIZE = 512,
  parameter logic [AW-1:0]   S1_BASE = 32'h2000_0000,
  parameter int unsigned     S1_SIZE = 512
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit0_o,
  output logic          hit1_o,
  output logic          unmapped_o
);

  // One extra bit so base+size never wraps past the top.
  localparam logic [AW:0] S0_LO = {1'b0, S0_BASE};
  localparam logic [AW:0] S0_HI = S0_LO + (AW+1)'(S0_SIZE);
  localparam logic [AW:0] S1_LO = {1'b0, S1_BASE};
  localparam logic [AW:0] S1_HI = S1_LO + (AW+1)'(S1_SIZE);

  logic [AW:0] a;
  logic        in0;
  logic        in1;

  assign a   = {1'b0, addr_i};
  assign in0 = (a >= S0_LO) && (a < S0_HI);
  assign in1 = (a >= S1_LO) && (a < S1_HI);

  assign hit0_o     = in0;
  assign hit1_o     = in1 && !in0;
  assign unmapped_o = !(in0 || in1);

endmodule

// File: rtl/leiwand_rv32_wb_intercon.sv
// Wishbone interconnect: core master to SRAM (s0) and ROM (s1).
// Optional slave-ack timeout: define LEIWAND_WB_TIMEOUT_EN.
module leiwand_rv32_wb_intercon
  import leiwand_rv32_wb_intercon_pkg::*;
#(
  parameter int unsigned          MEM_WIDTH      = 32,
  parameter logic [MEM_WIDTH-1:0] S0_BASE        = 32'h1000_0000,
  parameter int unsigned          S0_SIZE        = 512,
  parameter logic [MEM_WIDTH-1:0] S1_BASE        = 32'h2000_0000,
  parameter int unsigned          S1_SIZE        = 512,
  parameter int unsigned          TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_cyc,
  input  logic                 m_stb,
  input  logic                 m_we,
  input  logic [MEM_WIDTH-1:0] m_addr,
  input  logic [MEM_WIDTH-1:0] m_data_w,
  output logic [MEM_WIDTH-1:0] m_data_r,
  output logic                 m_ack,
  output logic                 m_stall,
  output logic                 m_err,
  output logic [MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0] s_data_w,
  output logic                 s_we,
  output logic                 s0_cyc,
  output logic                 s0_stb,
  input  logic [MEM_WIDTH-1:0] s0_data_r,
  input  logic                 s0_ack,
  input  logic                 s0_stall,
  output logic                 s1_cyc,
  output logic                 s1_stb,
  input  logic [MEM_WIDTH-1:0] s1_data_r,
  input  logic                 s1_ack,
  input  logic                 s1_stall
);

  logic hit0;
  logic hit1;
  logic unmapped;

  leiwand_rv32_wb_addr_decode #(
    .AW      (MEM_WIDTH),
    .S0_BASE (S0_BASE),
    .S0_SIZE (S0_SIZE),
    .S1_BASE (S1_BASE),
    .S1_SIZE (S1_SIZE)
  ) u_dec (
    .addr_i     (m_addr),
    .hit0_o     (hit0),
    .hit1_o     (hit1),
    .unmapped_o (unmapped)
  );

  assign s_addr   = m_addr;
  assign s_data_w = m_data_w;
  assign s_we     = m_we;

  wb_state_e state_q;
  wb_state_e state_d;
  logic      to_hit;

`ifdef LEIWAND_WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          waiting;

  assign waiting = (state_q == ST_WAIT_S0)
                || (state_q == ST_WAIT_S1);
  assign to_hit  = waiting
                && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (waiting) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  logic                 own_ack;
  logic [MEM_WIDTH-1:0] own_data;
  logic                 keep_cyc;

  always_comb begin
    state_d  = state_q;
    m_ack    = 1'b0;
    m_err    = 1'b0;
    m_stall  = 1'b0;
    m_data_r = '0;
    s0_cyc   = 1'b0;
    s0_stb   = 1'b0;
    s1_cyc   = 1'b0;
    s1_stb   = 1'b0;
    keep_cyc = 1'b0;
    own_ack  = (state_q == ST_WAIT_S1) ? s1_ack : s0_ack;
    own_data = (state_q == ST_WAIT_S1) ? s1_data_r
                                       : s0_data_r;
    unique case (state_q)
      ST_IDLE: begin
        s0_cyc  = m_cyc & hit0;
        s0_stb  = m_stb & hit0;
        s1_cyc  = m_cyc & hit1;
        s1_stb  = m_stb & hit1;
        m_stall = (hit0 & s0_stall) | (hit1 & s1_stall);
        if (m_cyc && m_stb && !m_stall) begin
          unique case (1'b1)
            hit0:     state_d = ST_WAIT_S0;
            hit1:     state_d = ST_WAIT_S1;
            unmapped: state_d = ST_ERR_ACK;
            default:  state_d = ST_ERR_ACK;
          endcase
        end
      end
      ST_WAIT_S0, ST_WAIT_S1: begin
        m_stall  = 1'b1;
        // A timeout drops cyc so the slave abandons the cycle.
        keep_cyc = m_cyc & (own_ack | !to_hit);
        s0_cyc   = keep_cyc & (state_q == ST_WAIT_S0);
        s1_cyc   = keep_cyc & (state_q == ST_WAIT_S1);
        if (!m_cyc) begin
          state_d = ST_IDLE;
        end else if (own_ack) begin
          m_ack    = 1'b1;
          m_data_r = own_data;
          state_d  = ST_IDLE;
        end else if (to_hit) begin
          m_ack   = 1'b1;
          m_err   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR_ACK: begin
        m_ack    = 1'b1;
        m_err    = 1'b1;
        m_stall  = 1'b1;
        m_data_r = `LEIWAND_WB_ERR_DATA;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) begin
      m_ack    = 1'b0;
      m_err    = 1'b0;
      m_stall  = 1'b0;
      m_data_r = '0;
      s0_cyc   = 1'b0;
      s0_stb   = 1'b0;
      s1_cyc   = 1'b0;
      s1_stb   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_intercon.sv
// Bench for leiwand_rv32_wb_intercon: directed cases plus
// random traffic scored against a memory-map reference model.
module tb_leiwand_rv32_wb_intercon;

  localparam logic [31:0] S0B = 32'h1000_0000;
  localparam logic [31:0] S1B = 32'h2000_0000;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_addr, m_data_w, m_data_r;
  logic        m_ack, m_stall, m_err;
  logic [31:0] s_addr, s_data_w;
  logic        s_we;
  logic        s0_cyc, s0_stb, s1_cyc, s1_stb;

  logic [1:0]  sl_ack, sl_stall;
  logic [31:0] sl_data [2];
  logic [1:0]  force_stall, force_ack;
  logic [1:0]  s_cyc_v, s_stb_v;
  bit   [1:0]  pend;
  int          cnt_s [2];
  logic [31:0] rdat [2];
  logic [31:0] smem [2][128];
  logic [31:0] model_mem [2][128];
  bit          rand_stall, rand_noise;
  int          lat_fix;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  leiwand_rv32_wb_intercon dut (
    .clk       (clk),
    .reset     (reset),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_data_w  (m_data_w),
    .m_data_r  (m_data_r),
    .m_ack     (m_ack),
    .m_stall   (m_stall),
    .m_err     (m_err),
    .s_addr    (s_addr),
    .s_data_w  (s_data_w),
    .s_we      (s_we),
    .s0_cyc    (s0_cyc),
    .s0_stb    (s0_stb),
    .s0_data_r (sl_data[0]),
    .s0_ack    (sl_ack[0]),
    .s0_stall  (sl_stall[0]),
    .s1_cyc    (s1_cyc),
    .s1_stb    (s1_stb),
    .s1_data_r (sl_data[1]),
    .s1_ack    (sl_ack[1]),
    .s1_stall  (sl_stall[1])
  );

  assign s_cyc_v = {s1_cyc, s0_cyc};
  assign s_stb_v = {s1_stb, s0_stb};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a,
                                input logic [31:0] base);
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(base);
    return (la >= lb) && (la < lb + 512);
  endfunction

  // Reference: memory map with two 128-word windows.
  function automatic exp_t ref_model(input bit we,
      input logic [31:0] a, input logic [31:0] wd);
    exp_t r;
    int   s;
    int   idx;
    r.rd = !we; r.err = 1'b0; r.data = '0;
    s = -1;
    if (in_win(a, S0B)) s = 0;
    else if (in_win(a, S1B)) s = 1;
    if (s < 0) begin
      r.err = 1'b1;
    end else begin
      idx = int'((64'(a) - 64'(s == 0 ? S0B : S1B)) / 4);
      if (we) model_mem[s][idx] = wd;
      else    r.data = model_mem[s][idx];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return S0B + 4 * $urandom_range(0, 127);
      3, 4, 5: return S1B + 4 * $urandom_range(0, 127);
      6: case ($urandom_range(0, 8))
        0: return 32'h0FFF_FFFC;
        1: return 32'h1000_0000;
        2: return 32'h1000_01FC;
        3: return 32'h1000_0200;
        4: return 32'h1FFF_FFFC;
        5: return 32'h2000_0000;
        6: return 32'h2000_01FC;
        7: return 32'h2000_0200;
        default: return 32'hFFFF_FFFC;
      endcase
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  // Slave models: random stall, variable ack latency, stray acks.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sl_ack   <= '0;
      sl_stall <= '0;
      pend     <= '0;
      for (int i = 0; i < 2; i++) begin
        sl_data[i] <= '0;
        cnt_s[i]   <= 0;
        rdat[i]    <= '0;
        for (int k = 0; k < 128; k++)
          smem[i][k] <= model_mem[i][k];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sl_ack[i]   <= 1'b0;
        sl_data[i]  <= $urandom;
        sl_stall[i] <= force_stall[i]
          | (rand_stall & ($urandom_range(0, 3) == 0));
        if (pend[i]) begin
          if (!s_cyc_v[i]) begin
            pend[i] <= 1'b0;
          end else if (cnt_s[i] == 0) begin
            sl_ack[i]  <= 1'b1;
            sl_data[i] <= rdat[i];
            pend[i]    <= 1'b0;
          end else begin
            cnt_s[i] <= cnt_s[i] - 1;
          end
        end else if (s_cyc_v[i] && s_stb_v[i]
                     && !sl_stall[i]) begin
          if (s_we) smem[i][s_addr[8:2]] <= s_data_w;
          if (lat_fix == 0 ||
              (lat_fix < 0 && $urandom_range(0, 2) == 0)) begin
            sl_ack[i]  <= 1'b1;
            sl_data[i] <= s_we ? 32'h0 : smem[i][s_addr[8:2]];
          end else begin
            pend[i]  <= 1'b1;
            cnt_s[i] <= (lat_fix < 0) ? $urandom_range(0, 1)
                                      : lat_fix - 1;
            rdat[i]  <= s_we ? 32'h0 : smem[i][s_addr[8:2]];
          end
        end else if (force_ack[i] ||
                     (rand_noise && $urandom_range(0, 7) == 0)) begin
          sl_ack[i] <= 1'b1;
        end
      end
    end
  end

  // Monitor: pops one expectation per master ack.
  always @(negedge clk) begin
    if (reset) begin
      if (s0_stb) chk("s0_stb_window", 32'(in_win(s_addr, S0B)), 1);
      if (s1_stb) chk("s1_stb_window", 32'(in_win(s_addr, S1B)), 1);
      if (m_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack expected none");
        end else begin
          chk("ack_err", 32'(m_err), 32'(exp_q[0].err));
          if (exp_q[0].rd || exp_q[0].err)
            chk("ack_data", m_data_r, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("noack_data_zero", m_data_r, 0);
      end
    end
  end

  task automatic txn(input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input bit to_err,
                     output int stall_n, output int lat_n);
    exp_t e;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
    m_addr = addr; m_data_w = wd;
    if (to_err) begin
      e.rd = !we; e.err = 1'b1; e.data = '0;
    end else begin
      e = ref_model(we, addr, wd);
    end
    exp_q.push_back(e);
    stall_n = 0;
    @(negedge clk);
    while (m_stall && stall_n < 64) begin
      stall_n++;
      @(negedge clk);
    end
    if (m_stall) chk("accept_timeout", 32'(m_stall), 0);
    @(posedge clk); #1;
    m_stb = 1'b0;
    lat_n = 0;
    do begin
      @(negedge clk);
      lat_n++;
    end while (!m_ack && lat_n < 64);
    if (!m_ack) chk("ack_timeout", 32'(m_ack), 1);
    if (to_err) chk("to_s0_cyc", 32'(s0_cyc), 0);
    if (e.err && !to_err) begin
      chk("unmapped_stall", stall_n, 0);
      chk("unmapped_lat", lat_n, 1);
    end
    @(posedge clk); #1;
    m_cyc = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_m_ack"}, 32'(m_ack), 0);
    chk({nm, "_m_err"}, 32'(m_err), 0);
    chk({nm, "_m_stall"}, 32'(m_stall), 0);
    chk({nm, "_m_data_r"}, m_data_r, 0);
    chk({nm, "_slave_cyc_stb"},
        32'({s0_cyc, s0_stb, s1_cyc, s1_stb}), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, lt;
    reset = 1'b0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    m_addr = 32'h1000_0004; m_data_w = '0;
    rand_stall = 1'b0; rand_noise = 1'b0; lat_fix = 0;
    force_stall = '0; force_ack = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 128; k++)
        model_mem[s][k] = $urandom;
    model_mem[0][1] = 32'h43;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // SRAM read, ack in the first wait cycle
    txn(1'b0, 32'h1000_0004, 0, 1'b0, st, lt);
    chk("sram_read_latency", lt, 1);

    // ROM write then readback
    txn(1'b1, 32'h2000_00FC, 32'hDEAD_BEEF, 1'b0, st, lt);
    txn(1'b0, 32'h2000_00FC, 0, 1'b0, st, lt);

    // unmapped read
    txn(1'b0, 32'h3000_0000, 0, 1'b0, st, lt);

    // SRAM stalls three cycles
    @(posedge clk); #1;
    force_stall[0] = 1'b1;
    fork
      txn(1'b0, 32'h1000_0000, 0, 1'b0, st, lt);
      begin
        repeat (3) @(posedge clk);
        #1 force_stall[0] = 1'b0;
      end
    join
    chk("stall_cycles", st, 3);

    // master abort in WAIT_S1 followed by a late s1 ack
    lat_fix = 5;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    m_addr = 32'h2000_0010;
    @(posedge clk); #1;
    m_stb = 1'b0;
    @(posedge clk); #1;
    m_cyc = 1'b0;
    @(negedge clk);
    chk("abort_s1_cyc", 32'(s1_cyc), 0);
    chk("abort_no_ack", 32'(m_ack), 0);
    @(posedge clk); #1;
    force_ack[1] = 1'b1;
    @(posedge clk); #1;
    force_ack[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_dropped", 32'(m_ack), 0);
    end
    lat_fix = 0;
    txn(1'b0, 32'h2000_0010, 0, 1'b0, st, lt);
    chk("after_abort_latency", lt, 1);

    // reset asserted during WAIT_S0
    lat_fix = 5;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_addr = 32'h1000_0008;
    @(posedge clk); #1;
    m_stb = 1'b0;
    #2 reset = 1'b0;
    #1 chk_outputs_zero("mid_wait_reset");
    m_cyc = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lat_fix = 0;

`ifdef LEIWAND_WB_TIMEOUT_EN
    lat_fix = 100;
    txn(1'b0, 32'h1000_0000, 0, 1'b1, st, lt);
    chk("timeout_latency", lt, TO);
    lat_fix = 0;
    txn(1'b0, 32'h1000_0004, 0, 1'b0, st, lt);
    chk("after_timeout_latency", lt, 1);
`endif

    // random traffic with stalls, latencies and stray acks
    rand_stall = 1'b1;
    rand_noise = 1'b1;
    lat_fix = -1;
    repeat (300)
      txn(1'(($urandom_range(0, 2)) == 0), rand_addr(),
          $urandom, 1'b0, st, lt);
    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
